seg_rx: RTL and testbench

Receive-side counterpart of the team's hex-to-seven-segment encoder. It observes a multiplexed, active-low seven-segment bus (segment lines plus one-hot active-low digit anodes) and reconstructs the displayed hex digits. Each digit is debounced and decoded; a complete frame is presented on a valid/ready output. It sits in self-test and loopback paths, where it checks display drivers without external equipment.

---
 rtl/seg_rx.sv | 232 +++++++++++++++++++++++
 tb/tb_seg_rx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_rx.sv
// Seven-segment bus receiver: debounces each multiplexed digit, decodes glyphs, emits frames.
// Optional SEG_RX_DROP_CNT_EN adds a saturating dropped-frame counter port.
module seg_rx #(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned STABLE_CYC = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     an_in,
  output logic [4*DIGITS-1:0]   frame_data,
  output logic [DIGITS-1:0]     frame_blank,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic                  bad_pat,
  output logic [2:0]            bad_digit
`ifdef SEG_RX_DROP_CNT_EN
  ,
  output logic [7:0]            drop_cnt
`endif
);

  typedef enum logic [1:0] {StIdle, StTrack, StHeld} state_e;

  logic [6:0]          seg_r;
  logic [DIGITS-1:0]   an_r;

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [DIGITS-1:0]   trk_an_q, trk_an_d;
  logic [6:0]          trk_seg_q, trk_seg_d;

  logic [3:0]          zcnt;
  logic [2:0]          an_idx;
  logic                an_valid;
  logic                same_pair;
  logic                commit;

  logic [3:0]          dec_nib;
  logic                dec_legal, dec_blank;
  logic                good_commit, bad_commit;

  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [DIGITS-1:0]   sblank_q, sblank_d;
  logic [DIGITS-1:0]   capture_q, capture_d;
  logic                complete, out_free;

  logic [4*DIGITS-1:0] frame_data_q;
  logic [DIGITS-1:0]   frame_blank_q;
  logic                frame_valid_q;
  logic                bad_pat_q;
  logic [2:0]          bad_digit_q;

  // Input stage: anodes reset to inactive so the FSM starts idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_r <= '0;
      an_r  <= '1;
    end else begin
      seg_r <= seg_in;
      an_r  <= an_in;
    end
  end

  always_comb begin
    zcnt   = '0;
    an_idx = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (!an_r[i]) begin
        zcnt   = zcnt + 4'd1;
        an_idx = 3'(i);
      end
    end
    an_valid = (zcnt == 4'd1);
  end

  assign same_pair = (an_r == trk_an_q) && (seg_r == trk_seg_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      trk_an_q  <= '1;
      trk_seg_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      trk_an_q  <= trk_an_d;
      trk_seg_q <= trk_seg_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    trk_an_d  = trk_an_q;
    trk_seg_d = trk_seg_q;
    commit    = 1'b0;
    if (!an_valid) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          state_d   = StTrack;
          cnt_d     = 8'd1;
          trk_an_d  = an_r;
          trk_seg_d = seg_r;
        end
        StTrack: begin
          if (same_pair) begin
            // cnt_q counts samples already seen; this edge supplies the last one.
            if (cnt_q == 8'(STABLE_CYC - 1)) begin
              commit  = 1'b1;
              state_d = StHeld;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end else begin
            cnt_d     = 8'd1;
            trk_an_d  = an_r;
            trk_seg_d = seg_r;
          end
        end
        StHeld: begin
          if (!same_pair) begin
            state_d   = StTrack;
            cnt_d     = 8'd1;
            trk_an_d  = an_r;
            trk_seg_d = seg_r;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    dec_nib   = '0;
    dec_legal = 1'b1;
    dec_blank = 1'b0;
    case (seg_r)
      7'b1000000: dec_nib = 4'h0;
      7'b1111001: dec_nib = 4'h1;
      7'b0100100: dec_nib = 4'h2;
      7'b0110000: dec_nib = 4'h3;
      7'b0011001: dec_nib = 4'h4;
      7'b0010010: dec_nib = 4'h5;
      7'b0000010: dec_nib = 4'h6;
      7'b1111000: dec_nib = 4'h7;
      7'b0000000: dec_nib = 4'h8;
      7'b0010000: dec_nib = 4'h9;
      7'b0001000: dec_nib = 4'hA;
      7'b0000011: dec_nib = 4'hB;
      7'b1000110: dec_nib = 4'hC;
      7'b0100001: dec_nib = 4'hD;
      7'b0000110: dec_nib = 4'hE;
      7'b0001110: dec_nib = 4'hF;
      7'b1111111: begin
        dec_legal = 1'b0;
        dec_blank = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  assign good_commit = commit && (dec_legal || dec_blank);
  assign bad_commit  = commit && !dec_legal && !dec_blank;
  assign complete    = &capture_q;
  assign out_free    = !frame_valid_q || frame_ready;

  always_comb begin
    shadow_d  = shadow_q;
    sblank_d  = sblank_q;
    capture_d = complete ? '0 : capture_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (good_commit && (an_idx == 3'(i))) begin
        shadow_d[4*i +: 4] = dec_blank ? 4'h0 : dec_nib;
        sblank_d[i]        = dec_blank;
        capture_d[i]       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q      <= '0;
      sblank_q      <= '0;
      capture_q     <= '0;
      frame_data_q  <= '0;
      frame_blank_q <= '0;
      frame_valid_q <= 1'b0;
      bad_pat_q     <= 1'b0;
      bad_digit_q   <= '0;
    end else begin
      shadow_q  <= shadow_d;
      sblank_q  <= sblank_d;
      capture_q <= capture_d;
      bad_pat_q <= bad_commit;
      if (bad_commit) bad_digit_q <= an_idx;
      if (complete && out_free) begin
        frame_data_q  <= shadow_q;
        frame_blank_q <= sblank_q;
        frame_valid_q <= 1'b1;
      end else if (frame_valid_q && frame_ready) begin
        frame_valid_q <= 1'b0;
      end
    end
  end

`ifdef SEG_RX_DROP_CNT_EN
  logic [7:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else if (complete && !out_free && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

  assign frame_data  = frame_data_q;
  assign frame_blank = frame_blank_q;
  assign frame_valid = frame_valid_q;
  assign bad_pat     = bad_pat_q;
  assign bad_digit   = bad_digit_q;

endmodule

// File: tb/tb_seg_rx.sv
// Directed, table-driven bench for seg_rx (DIGITS=4, STABLE_CYC=4).
module tb_seg_rx;

  localparam int unsigned DIGITS     = 4;
  localparam int unsigned STABLE_CYC = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg_in;
  logic [3:0]  an_in;
  logic [15:0] frame_data;
  logic [3:0]  frame_blank;
  logic        frame_valid;
  logic        frame_ready;
  logic        bad_pat;
  logic [2:0]  bad_digit;
`ifdef SEG_RX_DROP_CNT_EN
  logic [7:0]  drop_cnt;
`endif

  seg_rx #(
    .DIGITS     (DIGITS),
    .STABLE_CYC (STABLE_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .an_in       (an_in),
    .frame_data  (frame_data),
    .frame_blank (frame_blank),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .bad_pat     (bad_pat),
    .bad_digit   (bad_digit)
`ifdef SEG_RX_DROP_CNT_EN
    ,
    .drop_cnt    (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] nibs;
    logic [3:0]  blanks;
    logic [15:0] exp_data;
    logic [3:0]  exp_blank;
  } vec_t;

  vec_t       vecs [6];
  logic [6:0] glyph [16];
  int         n_cmp = 0;
  int         n_fail = 0;
  int         fv_total = 0;
  int         bp_total = 0;

  always @(negedge clk) begin
    if (frame_valid) fv_total++;
    if (bad_pat) bp_total++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_digit(input int d, input logic [6:0] s, input int n);
    an_in  = ~(4'b0001 << d);
    seg_in = s;
    step(n);
  endtask

  task automatic idle(input int n);
    an_in  = 4'hF;
    seg_in = 7'h7F;
    step(n);
  endtask

  task automatic send_frame(input logic [15:0] nibs);
    for (int d = 0; d < 4; d++) drive_digit(d, glyph[nibs[4*d +: 4]], 6);
    idle(2);
  endtask

  initial begin
    logic [3:0]  nb;
    logic [6:0]  s;
    logic [15:0] nibs;
    int          base;
    int          bpb;

    glyph[0]  = 7'b1000000; glyph[1]  = 7'b1111001; glyph[2]  = 7'b0100100;
    glyph[3]  = 7'b0110000; glyph[4]  = 7'b0011001; glyph[5]  = 7'b0010010;
    glyph[6]  = 7'b0000010; glyph[7]  = 7'b1111000; glyph[8]  = 7'b0000000;
    glyph[9]  = 7'b0010000; glyph[10] = 7'b0001000; glyph[11] = 7'b0000011;
    glyph[12] = 7'b1000110; glyph[13] = 7'b0100001; glyph[14] = 7'b0000110;
    glyph[15] = 7'b0001110;

    vecs[0] = '{nibs: 16'hFA73, blanks: 4'b0000, exp_data: 16'hFA73, exp_blank: 4'b0000};
    vecs[1] = '{nibs: 16'h3210, blanks: 4'b0000, exp_data: 16'h3210, exp_blank: 4'b0000};
    vecs[2] = '{nibs: 16'hCB98, blanks: 4'b0000, exp_data: 16'hCB98, exp_blank: 4'b0000};
    vecs[3] = '{nibs: 16'h7654, blanks: 4'b0010, exp_data: 16'h7604, exp_blank: 4'b0010};
    vecs[4] = '{nibs: 16'h9FED, blanks: 4'b1000, exp_data: 16'h0FED, exp_blank: 4'b1000};
    vecs[5] = '{nibs: 16'h1234, blanks: 4'b1111, exp_data: 16'h0000, exp_blank: 4'b1111};

    rst = 1'b1;
    frame_ready = 1'b1;
    an_in = 4'hF;
    seg_in = 7'h7F;
    step(3);
    chk("reset frame_data", 32'(frame_data), 32'h0);
    chk("reset frame_blank", 32'(frame_blank), 32'h0);
    chk("reset frame_valid", 32'(frame_valid), 32'h0);
    chk("reset bad_pat", 32'(bad_pat), 32'h0);
    chk("reset bad_digit", 32'(bad_digit), 32'h0);
`ifdef SEG_RX_DROP_CNT_EN
    chk("reset drop_cnt", 32'(drop_cnt), 32'h0);
`endif
    rst = 1'b0;
    step(2);

    // Table: each frame must appear exactly one edge after the last commit, for one cycle.
    for (int v = 0; v < 6; v++) begin
      for (int d = 0; d < 4; d++) begin
        nibs = vecs[v].nibs;
        nb   = nibs[4*d +: 4];
        s    = vecs[v].blanks[d] ? 7'h7F : glyph[nb];
        drive_digit(d, s, (d == 3) ? 5 : 6);
      end
      chk($sformatf("vec%0d valid before load", v), 32'(frame_valid), 32'h0);
      step(1);
      chk($sformatf("vec%0d valid", v), 32'(frame_valid), 32'h1);
      chk($sformatf("vec%0d data", v), 32'(frame_data), 32'(vecs[v].exp_data));
      chk($sformatf("vec%0d blank", v), 32'(frame_blank), 32'(vecs[v].exp_blank));
      step(1);
      chk($sformatf("vec%0d valid drop", v), 32'(frame_valid), 32'h0);
      idle(2);
    end

    // Glitch on digit 2: short "2" must not commit, following "5" must.
    base = fv_total;
    bpb  = bp_total;
    drive_digit(0, glyph[10], 6);
    drive_digit(1, glyph[11], 6);
    drive_digit(2, glyph[2], 2);
    drive_digit(2, glyph[5], 6);
    drive_digit(3, glyph[12], 6);
    idle(2);
    chk("glitch frames", 32'(fv_total - base), 32'd1);
    chk("glitch data", 32'(frame_data), 32'hC5BA);
    chk("glitch bad_pat", 32'(bp_total - bpb), 32'd0);

    // Illegal pattern on digit 1 blocks the frame until replaced by a legal glyph.
    base = fv_total;
    bpb  = bp_total;
    drive_digit(0, glyph[1], 6);
    drive_digit(1, 7'b1010101, 5);
    chk("illegal bad_pat pulse", 32'(bad_pat), 32'h1);
    chk("illegal bad_digit", 32'(bad_digit), 32'h1);
    step(1);
    chk("illegal bad_pat low", 32'(bad_pat), 32'h0);
    drive_digit(2, glyph[3], 6);
    drive_digit(3, glyph[4], 6);
    idle(2);
    chk("illegal no frame", 32'(fv_total - base), 32'd0);
    chk("illegal one pulse", 32'(bp_total - bpb), 32'd1);
    drive_digit(1, glyph[5], 6);
    idle(2);
    chk("illegal then legal frame", 32'(fv_total - base), 32'd1);
    chk("illegal then legal data", 32'(frame_data), 32'h4351);
    chk("bad_digit held", 32'(bad_digit), 32'h1);

    // Two anodes low with digits 0..2 already captured: nothing may commit.
    base = fv_total;
    drive_digit(0, glyph[1], 6);
    drive_digit(1, glyph[2], 6);
    drive_digit(2, glyph[3], 6);
    an_in  = 4'b0011;
    seg_in = glyph[8];
    step(20);
    idle(2);
    chk("multi-anode no frame", 32'(fv_total - base), 32'd0);
    chk("multi-anode valid", 32'(frame_valid), 32'h0);

    // Reset discards the partial capture; digit 3 alone is not a frame.
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("mid reset frame_data", 32'(frame_data), 32'h0);
    idle(2);
    drive_digit(3, glyph[14], 6);
    idle(3);
    chk("post-reset no frame", 32'(fv_total - base), 32'd0);
    drive_digit(0, glyph[6], 6);
    drive_digit(1, glyph[7], 6);
    drive_digit(2, glyph[8], 6);
    idle(2);
    chk("post-reset frame", 32'(fv_total - base), 32'd1);
    chk("post-reset data", 32'(frame_data), 32'hE876);

    // Back-pressure: first frame held, second dropped, third loads on the accepting edge.
    frame_ready = 1'b0;
    send_frame(16'h4321);
    chk("bp first valid", 32'(frame_valid), 32'h1);
    chk("bp first data", 32'(frame_data), 32'h4321);
    send_frame(16'h8765);
    chk("bp held valid", 32'(frame_valid), 32'h1);
    chk("bp held data", 32'(frame_data), 32'h4321);
`ifdef SEG_RX_DROP_CNT_EN
    chk("bp drop_cnt", 32'(drop_cnt), 32'd1);
`endif
    nibs = 16'hBA09;
    for (int d = 0; d < 3; d++) drive_digit(d, glyph[nibs[4*d +: 4]], 6);
    drive_digit(3, glyph[11], 5);
    frame_ready = 1'b1;
    step(1);
    chk("accept+load valid", 32'(frame_valid), 32'h1);
    chk("accept+load data", 32'(frame_data), 32'hBA09);
    step(1);
    chk("accept+load drop", 32'(frame_valid), 32'h0);
`ifdef SEG_RX_DROP_CNT_EN
    chk("final drop_cnt", 32'(drop_cnt), 32'd1);
`endif
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
